alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one ALU datapath (operand pair + SEL_WIDTH op select into the ALU result mux) among
//  N_REQ requesters. Round-robin arbitration; each job is a 3-phase GRANT/EXEC/RESP sequence.
//  Sits between requester masters and the structural ALU. Drives the ALU's op select and
//  operands, and captures its combinational result.
// PARAMETERS
//  DATA_WIDTH  8  operand/result width
//  SEL_WIDTH   3  ALU op select width; all 2**SEL_WIDTH codes are legal and passed through
//  N_REQ       4  number of requesters, >=1
//  ID_W        derived localparam = max(1,$clog2(N_REQ))
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst_n      in   1                  reset, synchronous, active-low
//  req_valid  in   N_REQ              per-requester job request
//  req_ready  out  N_REQ              one-hot accept; high only in IDLE, only for the winner
//  req_op     in   N_REQ*SEL_WIDTH    packed op codes, requester i at [i*SEL_WIDTH +: SEL_WIDTH]
//  req_a      in   N_REQ*DATA_WIDTH   packed operand A, same packing
//  req_b      in   N_REQ*DATA_WIDTH   packed operand B, same packing
//  rsp_valid  out  N_REQ              one-hot result valid to the granted requester
//  rsp_ready  in   N_REQ              per-requester result accept
//  rsp_data   out  DATA_WIDTH         result, stable while rsp_valid is high
//  alu_op     out  SEL_WIDTH          to the ALU mux select
//  alu_a      out  DATA_WIDTH         to the ALU
//  alu_b      out  DATA_WIDTH         to the ALU
//  alu_y      in   DATA_WIDTH         ALU combinational result
//  busy       out  1                  high in EXEC or RESP
//  grant_id   out  ID_W               index of the current/last granted requester
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; ptr=N_REQ-1, so requester 0 has first priority.
//   All outputs reset to 0: req_ready, rsp_valid, rsp_data, alu_*, busy, grant_id.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE
//   - winner = first i with req_valid[i], searching ptr+1, ptr+2, ... modulo N_REQ.
//   - Combinational req_ready[winner]=1. The handshake fires in that same cycle.
//   - At the clock edge: latch op/a/b of the winner, set grant_id=winner, go to EXEC.
//   - No valid requests: stay in IDLE, all req_ready=0.
//  EXEC (1 cycle)
//   - alu_op/alu_a/alu_b driven from the latched registers. Otherwise they hold their last value.
//   - At the edge: rsp_data <= alu_y; go to RESP.
//  RESP
//   - rsp_valid[grant_id]=1 (registered). rsp_data is held.
//   - Advance on rsp_ready[grant_id]: go to IDLE, ptr <= grant_id.
//   - rsp_ready of other requesters is ignored. Waits indefinitely with data stable.
//  Latency and throughput
//   - Accept-to-rsp_valid latency = 2 cycles.
//   - Best-case throughput = 1 job per 3 cycles.
//  Arithmetic: none in this block; widths pass through unchanged. ptr wraps N_REQ-1 -> 0.
//  Boundary conditions
//   - req_valid may drop before it is accepted: no job is issued and there is no side effect.
//   - req_valid changes outside IDLE are ignored.
//   - N_REQ=1: arbitration degenerates to always-grant-0; grant_id is 1 bit, always 0.
//   - The granted requester re-asserting in the same cycle it accepts its response:
//     considered next IDLE cycle at lowest priority (fairness).
//   - Reset mid-EXEC/RESP: job is discarded, no rsp_valid is issued, ptr returns to N_REQ-1.
// STRUCTURE
//  Package alu_pkg
//   - state encoding localparams: ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
//   - ALU op code constants shared with the ALU.
//  Sub-module alu_rr_picker
//   - combinational round-robin search; inputs (req, ptr), outputs (found, idx).
//   - The arbiter owns ptr and the FSM.
// TESTING
//  1. Reset: hold rst_n=0 2 cycles with req_valid=4'b1111
//     -> all outputs 0, no req_ready; first grant after release is to 0.
//  2. Single job: req 2 with op=3'd0, a=8'h05, b=8'h03, ALU model alu_y=a+b
//     -> req_ready=4'b0100 in accept cycle; rsp_valid=4'b0100 two cycles later; rsp_data=8'h08.
//  3. Fairness: all four requesting continuously, rsp_ready tied high
//     -> grant order 0,1,2,3,0; one job every 3 cycles.
//  4. Backpressure: rsp_ready=0 for 10 cycles in RESP
//     -> rsp_valid and rsp_data stable, no req_ready asserted; completes on rsp_ready=1.
//  5. Wrong responder: in RESP for id 1, assert rsp_ready=4'b0001 -> stays in RESP.
//  6. Mid-op reset: assert rst_n=0 in EXEC -> no rsp_valid; next grant goes to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU arbiter definitions: FSM state encoding and ALU op-code constants.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
// master = requesters plus the ALU result driver; slave = the arbiter itself.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int N_REQ      = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*SEL_WIDTH-1:0]  req_op;
  logic [N_REQ*DATA_WIDTH-1:0] req_a;
  logic [N_REQ*DATA_WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            rsp_valid;
  logic [N_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic [SEL_WIDTH-1:0]        alu_op;
  logic [DATA_WIDTH-1:0]       alu_a;
  logic [DATA_WIDTH-1:0]       alu_b;
  logic [DATA_WIDTH-1:0]       alu_y;
  logic                        busy;
  logic [ID_W-1:0]             grant_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_y,
    input  req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b, busy, grant_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_y,
    output req_ready, rsp_valid, rsp_data, alu_op, alu_a, alu_b, busy, grant_id
  );

endinterface

// File: rtl/alu_rr_picker.sv
// Combinational round-robin search: first set request after i_ptr, wrapping modulo N_REQ.
// The requester at i_ptr itself is checked last, giving it lowest priority.
module alu_rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_found,
  output logic [ID_W-1:0]  o_idx
);

  int w_cand;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = (int'(i_ptr) + k) % N_REQ;
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin owner of one shared ALU; each job runs IDLE accept -> EXEC -> RESP (2 cycles accept to rsp_valid).
// RESP holds rsp_valid/rsp_data until the granted requester's rsp_ready; no new accepts meanwhile.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int N_REQ      = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_grant;
  logic [N_REQ-1:0]      r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rsp_dat;
  logic [SEL_WIDTH-1:0]  r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  r_busy;

  logic                  w_found;
  logic [ID_W-1:0]       w_idx;
  logic                  w_accept;
  logic [N_REQ-1:0]      w_req_rdy;

  alu_rr_picker #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .i_req  (bus.req_valid),
    .i_ptr  (r_ptr),
    .o_found(w_found),
    .o_idx  (w_idx)
  );

  // Gated by rst_n so no handshake can fire while reset is held.
  assign w_accept = rst_n && (r_state == ST_IDLE) && w_found;

  always_comb begin
    w_req_rdy = '0;
    if (w_accept) w_req_rdy[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= ID_W'(N_REQ - 1);
      r_grant   <= '0;
      r_rsp_vld <= '0;
      r_rsp_dat <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op[int'(w_idx)*SEL_WIDTH +: SEL_WIDTH];
            r_a     <= bus.req_a[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_b     <= bus.req_b[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_grant <= w_idx;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_dat          <= bus.alu_y;
          r_rsp_vld          <= '0;
          r_rsp_vld[r_grant] <= 1'b1;
          r_state            <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[r_grant]) begin
            r_rsp_vld <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= r_grant;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_rdy;
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_data  = r_rsp_dat;
  assign bus.alu_op    = r_op;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single job, fairness, backpressure, wrong responder, mid-op reset.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   fails;

  alu_arbiter_if #(.DATA_WIDTH(8), .SEL_WIDTH(3), .N_REQ(4)) bus ();

  alu_arbiter #(.DATA_WIDTH(8), .SEL_WIDTH(3), .N_REQ(4)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU model
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_y = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_y = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_y = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_y = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_y = bus.alu_a ^ bus.alu_b;
      OP_SHL:  bus.alu_y = bus.alu_a << 1;
      OP_SHR:  bus.alu_y = bus.alu_a >> 1;
      default: bus.alu_y = bus.alu_a;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-computed job table for requesters 0..3
  logic [2:0] exp_op [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
  logic [7:0] exp_a  [4] = '{8'h0a, 8'h32, 8'h05, 8'hf0};
  logic [7:0] exp_b  [4] = '{8'h14, 8'h08, 8'h03, 8'h3c};
  logic [7:0] exp_y  [4] = '{8'h1e, 8'h2a, 8'h08, 8'h30};
  int         order  [5] = '{0, 1, 2, 3, 0};

  initial begin
    total = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_op    = {3'd2, 3'd0, 3'd1, 3'd0};
    bus.req_a     = {8'hf0, 8'h05, 8'h32, 8'h0a};
    bus.req_b     = {8'h3c, 8'h03, 8'h08, 8'h14};
    bus.rsp_ready = 4'b0000;

    // 1. Reset held 2 cycles with all requesting
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
    chk("rst_alu_op",    32'(bus.alu_op),    32'h0);
    chk("rst_alu_a",     32'(bus.alu_a),     32'h0);
    chk("rst_alu_b",     32'(bus.alu_b),     32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_grant_id",  32'(bus.grant_id),  32'h0);

    // 3. Fairness: continuous requests, rsp_ready high
    rst_n = 1'b1;
    bus.rsp_ready = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("rr_req_ready", 32'(bus.req_ready), 32'h1 << order[j]);
      tick();
      chk("rr_busy_exec", 32'(bus.busy),      32'h1);
      chk("rr_grant_id",  32'(bus.grant_id),  32'(order[j]));
      chk("rr_alu_op",    32'(bus.alu_op),    32'(exp_op[order[j]]));
      chk("rr_alu_a",     32'(bus.alu_a),     32'(exp_a[order[j]]));
      chk("rr_alu_b",     32'(bus.alu_b),     32'(exp_b[order[j]]));
      chk("rr_rdy_exec",  32'(bus.req_ready), 32'h0);
      tick();
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1 << order[j]);
      chk("rr_rsp_data",  32'(bus.rsp_data),  32'(exp_y[order[j]]));
      tick();
      chk("rr_rsp_clear", 32'(bus.rsp_valid), 32'h0);
    end

    // Idle with no requests
    bus.req_valid = 4'b0000;
    #1;
    chk("idle_no_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // 2. Single job on requester 2
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 4'b0000;
    #1;
    chk("single_req_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_exec_rsp", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("single_rsp_data",  32'(bus.rsp_data),  32'h08);

    // 4. Backpressure for 10 cycles, new requests must not be accepted
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'h08);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 4'b0100;
    tick();
    bus.rsp_ready = 4'b0000;
    chk("bp_done_valid", 32'(bus.rsp_valid), 32'h0);
    chk("bp_next_winner", 32'(bus.req_ready), 32'h8);
    tick();
    tick();
    chk("bp_job3_data", 32'(bus.rsp_data), 32'h30);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b1000;
    tick();
    bus.rsp_ready = 4'b0000;

    // 5. Wrong responder while requester 1 is in RESP
    chk("wr_req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    bus.rsp_ready = 4'b0001;
    tick();
    chk("wr_still_valid", 32'(bus.rsp_valid), 32'h2);
    chk("wr_still_busy",  32'(bus.busy),      32'h1);
    chk("wr_data",        32'(bus.rsp_data),  32'h2a);
    bus.rsp_ready = 4'b0010;
    tick();
    bus.rsp_ready = 4'b0000;
    chk("wr_done", 32'(bus.busy), 32'h0);

    // 6. Reset during EXEC discards the job
    bus.req_valid = 4'b1000;
    #1;
    chk("mr_req_ready", 32'(bus.req_ready), 32'h8);
    tick();
    chk("mr_in_exec", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mr_busy",      32'(bus.busy),      32'h0);
    chk("mr_no_ready",  32'(bus.req_ready), 32'h0);
    tick();
    chk("mr_rsp_valid2", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    bus.rsp_ready = 4'b1111;
    #1;
    chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    chk("mr_grant_id", 32'(bus.grant_id), 32'h0);
    tick();
    chk("mr_rsp_valid3", 32'(bus.rsp_valid), 32'h1);
    chk("mr_rsp_data",   32'(bus.rsp_data),  32'h1e);
    tick();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
